ft2232_tx_arbiter: RTL and testbench
====================================

FT2232_TX_ARBITER -- requirements
Module: ft2232_tx_arbiter

Interface
REQ-001 SHALL have parameter MAX_PKT_BYTES, default 256, maximum bytes per grant before forced release (range 2..65535).
REQ-002 SHALL have ports, clock and reset first:
- clk_i  in  1  single clock, rising edge
- reset_i  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  audio requester byte valid
- req0_data_i  in  8  audio requester byte
- req0_last_i  in  1  last byte of audio packet
- req0_ready_o  out  1  audio byte accepted
- req1_valid_i / req1_data_i / req1_last_i / req1_ready_o  1/8/1/1  same roles, status/control requester
- tx_valid_o  out  1  byte valid toward ft2232_fifo write path
- tx_data_o  out  8  byte toward FIFO
- tx_last_o  out  1  last byte of current packet
- tx_ready_i  in  1  FIFO write path accepts byte
- grant_o  out  2  one-hot current owner (bit0 = req0, bit1 = req1)
- overrun_o  out  1  sticky: a packet hit MAX_PKT_BYTES without last
REQ-003 Clock and reset: one clock, clk_i; reset_i asynchronous and active-high.

Function
REQ-004 SHALL implement states IDLE, GRANT0, GRANT1.
REQ-005 In IDLE, tx_valid_o = 0, req*_ready_o = 0, grant_o = 2'b00.
REQ-006 In IDLE with any reqN_valid_i = 1, the next state SHALL be GRANTn, chosen per REQ-013/REQ-014; the grant decision takes exactly one cycle.
REQ-007 In GRANTn: tx_valid_o = reqN_valid_i, tx_data_o = reqN_data_i, tx_last_o = reqN_last_i, reqN_ready_o = tx_ready_i (combinational pass-through); the other requester's ready = 0.
REQ-008 A byte transfers when tx_valid_o and tx_ready_i are both 1 on a rising edge; no other condition counts.
REQ-009 A byte counter SHALL clear on entry to GRANTn and increment by 1 per transfer.
REQ-010 Transfer with tx_last_o = 1: return to IDLE the next cycle, and update last-served to n.
REQ-011 Transfer that makes the count equal MAX_PKT_BYTES with tx_last_o = 0: set overrun_o = 1, return to IDLE, and update last-served to n. overrun_o stays 1 until reset.
REQ-012 In GRANTn, a deasserted reqN_valid_i SHALL hold the grant; no timeout.
REQ-013 Round-robin: when both requesters are valid in IDLE, grant the one not last-served. When only one is valid, grant it.
REQ-014 Priority mode is defined under Configuration.
REQ-015 Packets SHALL never interleave: a grant is held until REQ-010 or REQ-011.
REQ-016 Bytes SHALL be neither dropped nor duplicated; tx_data_o SHALL be held stable while tx_valid_o = 1 and tx_ready_i = 0, provided the requester holds its inputs.

Reset
REQ-017 While reset_i = 1 and immediately on assertion: state = IDLE, counter = 0, last-served = req1 (so req0 wins the first tie), overrun_o = 0, grant_o = 0, tx_valid_o = 0, all ready = 0.
REQ-018 Reset mid-packet SHALL abandon the packet with no further transfers; the requester is responsible for restarting it.

Configuration
REQ-019 Macro AUDIO_PRIORITY_EN.
- Defined: in IDLE, req0 SHALL always win when valid; req1 is granted only when req0_valid_i = 0.
- Undefined: round-robin per REQ-013.
REQ-020 All other behaviour is identical in both builds.

Verification
REQ-021 Single packet: req0 sends 4 bytes 0x11..0x14, last on 0x14, tx_ready_i = 1 -> grant_o = 01 the cycle after valid; 4 transfers; IDLE the next cycle.
REQ-022 Tie: both valid after reset, each with 2-byte packets repeated -> grant order 0,1,0,1. With AUDIO_PRIORITY_EN -> 0,0,0 while req0 stays valid.
REQ-023 Backpressure: tx_ready_i = 0 for 5 cycles mid-packet -> tx_data_o stable, req0_ready_o = 0, no counter change.
REQ-024 Overrun: MAX_PKT_BYTES = 4, req1 sends 6 bytes, no last -> release after 4th byte, overrun_o = 1, req0 served next if valid.
REQ-025 Reset pulse on byte 2 of a 5-byte packet -> all outputs at reset values same cycle, overrun_o = 0, next grant follows the REQ-017 tie rule.

Source files
------------

// File: rtl/ft2232_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | ft2232_tx_arbiter: two-requester packet arbiter feeding the FT2232 TX FIFO. |
// | Define AUDIO_PRIORITY_EN for fixed req0 priority (default: round-robin).    |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module ft2232_tx_arbiter #(
    parameter int MAX_PKT_BYTES = 256
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       req0_valid_i,
    input  logic [7:0] req0_data_i,
    input  logic       req0_last_i,
    output logic       req0_ready_o,
    input  logic       req1_valid_i,
    input  logic [7:0] req1_data_i,
    input  logic       req1_last_i,
    output logic       req1_ready_o,
    output logic       tx_valid_o,
    output logic [7:0] tx_data_o,
    output logic       tx_last_o,
    input  logic       tx_ready_i,
    output logic [1:0] grant_o,
    output logic       overrun_o
);

    localparam int             CW        = 16;
    localparam logic [CW-1:0]  C_MAX_CNT = CW'(MAX_PKT_BYTES);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_GRANT0 = 2'd1;
    localparam logic [1:0] ST_GRANT1 = 2'd2;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last1_q, last1_d;   // 1 when req1 was the last requester served
    logic          overrun_q, overrun_d;

    logic          w_xfer;
    logic          w_tie_pick0;
    logic [CW-1:0] w_cnt_inc;

    always_comb begin
        tx_valid_o   = 1'b0;
        tx_data_o    = 8'h00;
        tx_last_o    = 1'b0;
        req0_ready_o = 1'b0;
        req1_ready_o = 1'b0;
        grant_o      = 2'b00;
        case (state_q)
            ST_GRANT0: begin
                tx_valid_o   = req0_valid_i;
                tx_data_o    = req0_data_i;
                tx_last_o    = req0_last_i;
                req0_ready_o = tx_ready_i;
                grant_o      = 2'b01;
            end
            ST_GRANT1: begin
                tx_valid_o   = req1_valid_i;
                tx_data_o    = req1_data_i;
                tx_last_o    = req1_last_i;
                req1_ready_o = tx_ready_i;
                grant_o      = 2'b10;
            end
            default: ;
        endcase
    end

    assign w_xfer    = tx_valid_o & tx_ready_i;
    assign w_cnt_inc = cnt_q + 1'b1;
    assign overrun_o = overrun_q;

`ifdef AUDIO_PRIORITY_EN
    assign w_tie_pick0 = 1'b1;
`else
    assign w_tie_pick0 = last1_q;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        last1_d   = last1_q;
        overrun_d = overrun_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (req0_valid_i && (!req1_valid_i || w_tie_pick0))
                    state_d = ST_GRANT0;
                else if (req1_valid_i)
                    state_d = ST_GRANT1;
            end
            ST_GRANT0, ST_GRANT1: begin
                if (w_xfer) begin
                    cnt_d = w_cnt_inc;
                    // A packet ends on its last byte, or is cut off at the size limit.
                    if (tx_last_o || (w_cnt_inc == C_MAX_CNT)) begin
                        state_d = ST_IDLE;
                        last1_d = (state_q == ST_GRANT1);
                        if (!tx_last_o)
                            overrun_d = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            last1_q   <= 1'b1;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last1_q   <= last1_d;
            overrun_q <= overrun_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ft2232_tx_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_ft2232_tx_arbiter: bench for ft2232_tx_arbiter against a packet model.   |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_ft2232_tx_arbiter;

    localparam int MAX = 4;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       req0_valid_i, req0_last_i, req0_ready_o;
    logic [7:0] req0_data_i;
    logic       req1_valid_i, req1_last_i, req1_ready_o;
    logic [7:0] req1_data_i;
    logic       tx_valid_o, tx_last_o, tx_ready_i;
    logic [7:0] tx_data_o;
    logic [1:0] grant_o;
    logic       overrun_o;

    ft2232_tx_arbiter #(.MAX_PKT_BYTES(MAX)) dut (
        .clk_i(clk_i), .reset_i(reset_i),
        .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i),
        .req0_last_i(req0_last_i), .req0_ready_o(req0_ready_o),
        .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i),
        .req1_last_i(req1_last_i), .req1_ready_o(req1_ready_o),
        .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o), .tx_last_o(tx_last_o),
        .tx_ready_i(tx_ready_i), .grant_o(grant_o), .overrun_o(overrun_o)
    );

    always #5 clk_i = ~clk_i;

    int total = 0;
    int bad   = 0;

    // Pending bytes per requester: {last, data}
    logic [8:0] q0[$];
    logic [8:0] q1[$];

    // Reference model: who owns the link, bytes sent in this grant, who went last
    int owner;      // -1 = nobody
    int sent;
    int last_served;
    bit m_overrun;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic void model_reset();
        owner       = -1;
        sent        = 0;
        last_served = 1;
        m_overrun   = 1'b0;
    endfunction

    task automatic push_pkt(input int r, input int len, input bit with_last, input logic [7:0] base);
        for (int i = 0; i < len; i++) begin
            logic [8:0] b;
            b = {with_last && (i == len - 1), base + 8'(i)};
            if (r == 0) q0.push_back(b); else q1.push_back(b);
        end
    endtask

    task automatic drive(input bit e0, input bit e1, input bit rdy);
        logic [8:0] h0, h1;
        h0 = (q0.size() > 0) ? q0[0] : 9'h000;
        h1 = (q1.size() > 0) ? q1[0] : 9'h000;
        req0_valid_i = e0 && (q0.size() > 0);
        req0_data_i  = h0[7:0];
        req0_last_i  = h0[8];
        req1_valid_i = e1 && (q1.size() > 0);
        req1_data_i  = h1[7:0];
        req1_last_i  = h1[8];
        tx_ready_i   = rdy;
    endtask

    task automatic check_outputs();
        logic       ev;
        logic [7:0] ed;
        logic       el;
        ev = (owner == 0) ? req0_valid_i : (owner == 1) ? req1_valid_i : 1'b0;
        ed = (owner == 1) ? req1_data_i : req0_data_i;
        el = (owner == 1) ? req1_last_i : req0_last_i;
        check("grant", 32'(grant_o), (owner == 0) ? 32'd1 : (owner == 1) ? 32'd2 : 32'd0);
        check("tx_valid", 32'(tx_valid_o), 32'(ev));
        if (ev) begin
            check("tx_data", 32'(tx_data_o), 32'(ed));
            check("tx_last", 32'(tx_last_o), 32'(el));
        end
        check("ready0", 32'(req0_ready_o), 32'((owner == 0) && tx_ready_i));
        check("ready1", 32'(req1_ready_o), 32'((owner == 1) && tx_ready_i));
        check("overrun", 32'(overrun_o), 32'(m_overrun));
    endtask

    // Advance the model across one rising edge using the inputs held over it.
    task automatic model_step();
        logic [8:0] b;
        if (owner < 0) begin
            sent = 0;
            if (req0_valid_i && req1_valid_i) begin
`ifdef AUDIO_PRIORITY_EN
                owner = 0;
`else
                owner = (last_served == 0) ? 1 : 0;
`endif
            end else if (req0_valid_i) owner = 0;
            else if (req1_valid_i) owner = 1;
        end else if (((owner == 0) ? req0_valid_i : req1_valid_i) && tx_ready_i) begin
            b = (owner == 0) ? q0.pop_front() : q1.pop_front();
            sent++;
            if (b[8]) begin
                last_served = owner;
                owner       = -1;
            end else if (sent == MAX) begin
                m_overrun   = 1'b1;
                last_served = owner;
                owner       = -1;
            end
        end
    endtask

    task automatic do_cycle(input bit e0, input bit e1, input bit rdy);
        @(negedge clk_i);
        drive(e0, e1, rdy);
        #1 check_outputs();
        @(posedge clk_i);
        model_step();
    endtask

    // Reset asserted between edges: outputs must collapse immediately.
    task automatic pulse_reset();
        @(negedge clk_i);
        #2 reset_i = 1'b1;
        #1;
        check("rst_grant", 32'(grant_o), 32'd0);
        check("rst_valid", 32'(tx_valid_o), 32'd0);
        check("rst_ready", 32'({req0_ready_o, req1_ready_o}), 32'd0);
        check("rst_overrun", 32'(overrun_o), 32'd0);
        model_reset();
        q0.delete();
        q1.delete();
        drive(1'b0, 1'b0, 1'b0);
        @(negedge clk_i);
        reset_i = 1'b0;
    endtask

    initial begin
        reset_i = 1'b1;
        model_reset();
        drive(1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk_i);
        pulse_reset();

        // Single 4-byte packet from req0
        push_pkt(0, 4, 1'b1, 8'h11);
        repeat (7) do_cycle(1'b1, 1'b0, 1'b1);

        // Tie: both requesters stream 2-byte packets
        for (int i = 0; i < 3; i++) begin
            push_pkt(0, 2, 1'b1, 8'h20 + 8'(i * 2));
            push_pkt(1, 2, 1'b1, 8'hA0 + 8'(i * 2));
        end
        repeat (24) do_cycle(1'b1, 1'b1, 1'b1);

        // Backpressure mid-packet
        push_pkt(0, 4, 1'b1, 8'h30);
        repeat (2) do_cycle(1'b1, 1'b0, 1'b1);
        repeat (5) do_cycle(1'b1, 1'b0, 1'b0);
        repeat (5) do_cycle(1'b1, 1'b0, 1'b1);

        // Overrun: req1 runs past the limit, req0 waits behind it
        push_pkt(1, 6, 1'b0, 8'h50);
        push_pkt(1, 1, 1'b1, 8'h56);
        repeat (2) do_cycle(1'b0, 1'b1, 1'b1);
        push_pkt(0, 2, 1'b1, 8'h60);
        repeat (20) do_cycle(1'b1, 1'b1, 1'b1);

        // Reset on byte 2 of a 5-byte packet, then the tie rule again
        push_pkt(0, 5, 1'b1, 8'h70);
        repeat (3) do_cycle(1'b1, 1'b0, 1'b1);
        pulse_reset();
        push_pkt(0, 1, 1'b1, 8'h80);
        push_pkt(1, 1, 1'b1, 8'h90);
        repeat (6) do_cycle(1'b1, 1'b1, 1'b1);

        // Random traffic
        for (int c = 0; c < 3000; c++) begin
            if (q0.size() == 0) begin
                if ($urandom_range(7) == 0) push_pkt(0, MAX, 1'b0, 8'($urandom));
                else push_pkt(0, int'($urandom_range(6, 1)), 1'b1, 8'($urandom));
            end
            if (q1.size() == 0) begin
                if ($urandom_range(7) == 0) push_pkt(1, MAX, 1'b0, 8'($urandom));
                else push_pkt(1, int'($urandom_range(6, 1)), 1'b1, 8'($urandom));
            end
            if ($urandom_range(499) == 0) pulse_reset();
            else do_cycle($urandom_range(3) != 0, $urandom_range(3) != 0,
                          $urandom_range(3) != 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
